// File: rtl/fetch_controller_pkg.sv
// fetch_controller_pkg: fetch-stage state encoding and alignment constants shared with decode and the CPU top
package fetch_controller_pkg;
  typedef enum logic [1:0] {FC_IDLE, FC_FETCH, FC_FAULT} fc_state_t;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
  function automatic logic misaligned(input logic [31:0] a);
    return (a[1:0] & ALIGN_MASK) != 2'b00;
  endfunction
endpackage

// File: rtl/fetch_wait_timer.sv
// fetch_wait_timer: counts consecutive unanswered request cycles and flags the one that reaches the limit
module fetch_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);
  logic [7:0] r_count;
  always_ff @(posedge clk)
    if (reset || i_clr) r_count <= '0;
    else if (i_en) r_count <= r_count + 8'd1;
  assign o_expired = i_en && (r_count == 8'(WAIT_LIMIT - 1));
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: fetch PC sequencing, one-entry instruction buffer, redirects and memory timeout fault
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] startAddress,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  input  logic        stall,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memReady,
  input  logic [31:0] memData,
  output logic        instrValid,
  output logic [31:0] instruction,
  output logic [31:0] pcOut,
  output logic [31:0] pcPlus4Out,
  output logic        running,
  output logic        memFault
);
  fc_state_t   r_state, w_state;
  logic [31:0] r_memAddr, w_memAddr, r_target, w_target, r_instr, w_instr, r_pc, w_pc;
  logic        r_valid, w_valid, r_pend, r_discard, w_discard;
  logic        w_consume, w_hs, w_wait, w_expired;
  assign w_consume = r_valid && !stall;
  // an outstanding request is held regardless of halt or stall until memory answers
  assign memReq = (r_state == FC_FETCH) && (r_pend || (!halt && (!r_valid || w_consume)));
  assign w_hs = memReq && memReady;
  assign w_wait = memReq && !memReady;
  fetch_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .clk(clk),
    .reset(reset),
    .i_en(w_wait),
    .i_clr(!w_wait),
    .o_expired(w_expired)
  );
  always_comb begin
    w_state = r_state;
    w_memAddr = r_memAddr;
    w_target = r_target;
    w_discard = r_discard;
    w_valid = r_valid && !w_consume;
    w_instr = r_instr;
    w_pc = r_pc;
    if (r_state != FC_FETCH) begin
      if (start) begin
        w_state = misaligned(startAddress) ? FC_FAULT : FC_FETCH;
        w_memAddr = misaligned(startAddress) ? r_memAddr : startAddress;
        w_valid = 1'b0;
        w_discard = 1'b0;
      end
    end else if (w_expired || (redirect && misaligned(redirectTarget))) begin
      w_state = FC_FAULT;
      w_valid = 1'b0;
      w_discard = 1'b0;
    end else begin
      if (halt && !w_wait) w_state = FC_IDLE;
      if (redirect) begin
        w_valid = 1'b0;
        w_discard = w_wait;
        w_target = redirectTarget;
        w_memAddr = w_wait ? r_memAddr : redirectTarget;
      end else if (w_hs) begin
        w_discard = 1'b0;
        w_memAddr = r_discard ? r_target : r_memAddr + INSTR_BYTES;
        w_valid = w_valid || !r_discard;
        w_instr = r_discard ? r_instr : memData;
        w_pc = r_discard ? r_pc : r_memAddr;
      end
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= FC_IDLE;
      r_memAddr <= RESET_ADDR;
      r_target <= RESET_ADDR;
      r_discard <= 1'b0;
      r_pend <= 1'b0;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc <= RESET_ADDR;
    end else begin
      r_state <= w_state;
      r_memAddr <= w_memAddr;
      r_target <= w_target;
      r_discard <= w_discard;
      r_pend <= w_wait;
      r_valid <= w_valid;
      r_instr <= w_instr;
      r_pc <= w_pc;
    end
  assign memAddr = r_memAddr;
  assign instrValid = r_valid;
  assign instruction = r_instr;
  assign pcOut = r_pc;
  assign pcPlus4Out = r_pc + INSTR_BYTES;
  assign running = r_state == FC_FETCH;
  assign memFault = r_state == FC_FAULT;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed literal checks plus randomized traffic against a transaction-level fetch model
module tb_fetch_controller;
  localparam int WL = 15;
  logic clk = 0, reset = 1, start = 0, halt = 0, redirect = 0, stall = 0, memReady = 0;
  logic [31:0] startAddress = 0, redirectTarget = 0, memData = 0;
  logic memReq, instrValid, running, memFault;
  logic [31:0] memAddr, instruction, pcOut, pcPlus4Out;
  int checks = 0, errors = 0;
  int mem_wait = 0, mem_rl = 0, mem_w = 0, n = 0;
  bit rnd = 0, last_req = 0, last_rdy = 0;
  int m_mode = 0, m_wait = 0;
  bit m_busy = 0, m_stale = 0, m_bv = 0, mv = 0, e_req, e_cons;
  logic [31:0] m_addr = 0, m_target = 0, m_bi = 0, m_bp = 0;
  fetch_controller #(.RESET_ADDR(32'h0), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset), .start(start), .startAddress(startAddress), .halt(halt),
    .redirect(redirect), .redirectTarget(redirectTarget), .stall(stall), .memReq(memReq),
    .memAddr(memAddr), .memReady(memReady), .memData(memData), .instrValid(instrValid),
    .instruction(instruction), .pcOut(pcOut), .pcPlus4Out(pcPlus4Out), .running(running),
    .memFault(memFault)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic nx();
    @(posedge clk);
    #1;
  endtask
  // memory: answers after a chosen number of wait cycles, data is a fixed function of the address
  always begin
    @(negedge clk);
    last_req = memReq;
    last_rdy = memReady;
    @(posedge clk);
    #2;
    mem_w = (last_req && !last_rdy) ? mem_w + 1 : 0;
    if (mem_w == 0)
      mem_rl = ($urandom_range(0, 49) == 0) ? 20 : ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
    memData = hash(memAddr);
    memReady = memReq ? (mem_w >= (rnd ? mem_rl : mem_wait)) : (rnd && $urandom_range(0, 1) == 1);
  end
  always begin
    @(negedge clk);
    e_req = (m_mode == 1) && (m_busy || (!halt && (!m_bv || !stall)));
    e_cons = m_bv && !stall;
    if (mv) begin
      chk("memReq", memReq, e_req);
      chk("memAddr", memAddr, m_addr);
      chk("instrValid", instrValid, m_bv);
      chk("instruction", instruction, m_bi);
      chk("pcOut", pcOut, m_bp);
      chk("pcPlus4Out", pcPlus4Out, m_bp + 32'd4);
      chk("running", running, m_mode == 1);
      chk("memFault", memFault, m_mode == 2);
    end
    if (reset) begin
      mv = 1; m_mode = 0; m_addr = 0; m_target = 0; m_bp = 0; m_bi = 0;
      m_bv = 0; m_busy = 0; m_stale = 0; m_wait = 0;
    end else if (mv) begin
      if (m_mode != 1) begin
        if (e_cons) m_bv = 0;
        if (start) begin
          m_bv = 0; m_busy = 0; m_stale = 0; m_wait = 0;
          if (startAddress[1:0] != 2'b00) m_mode = 2;
          else begin m_mode = 1; m_addr = startAddress; end
        end
      end else begin
        m_wait = (e_req && !memReady) ? m_wait + 1 : 0;
        if (m_wait == WL || (redirect && redirectTarget[1:0] != 2'b00)) begin
          m_mode = 2; m_bv = 0; m_busy = 0; m_stale = 0; m_wait = 0;
        end else begin
          if (redirect) begin
            m_bv = 0;
            if (e_req && !memReady) begin m_target = redirectTarget; m_stale = 1; end
            else begin m_addr = redirectTarget; m_stale = 0; end
          end else if (e_req && memReady) begin
            if (m_stale) begin m_addr = m_target; m_stale = 0; end
            else begin m_bi = hash(m_addr); m_bp = m_addr; m_bv = 1; m_addr = m_addr + 32'd4; end
          end else if (e_cons) m_bv = 0;
          m_busy = e_req && !memReady;
          if (halt && !m_busy) m_mode = 0;
        end
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst memReq", memReq, 0);
    chk("rst memAddr", memAddr, 0);
    chk("rst pcOut", pcOut, 0);
    chk("rst instrValid", instrValid, 0);
    chk("rst instruction", instruction, 0);
    chk("rst running", running, 0);
    chk("rst memFault", memFault, 0);
    nx(); start = 1; startAddress = 32'h100;
    @(negedge clk); chk("idle memReq", memReq, 0);
    nx(); start = 0;
    @(negedge clk); chk("f0 memAddr", memAddr, 32'h100); chk("f0 memReq", memReq, 1); chk("f0 running", running, 1);
    nx();
    @(negedge clk); chk("f1 memAddr", memAddr, 32'h104); chk("f1 pcOut", pcOut, 32'h100); chk("f1 valid", instrValid, 1);
    nx(); stall = 1;
    @(negedge clk); chk("st memReq", memReq, 0); chk("st pcOut", pcOut, 32'h104); chk("st memAddr", memAddr, 32'h108);
    repeat (2) begin
      nx();
      @(negedge clk); chk("st hold memReq", memReq, 0); chk("st hold pcOut", pcOut, 32'h104);
    end
    nx(); stall = 0;
    @(negedge clk); chk("unstall memReq", memReq, 1); chk("unstall memAddr", memAddr, 32'h108);
    nx(); mem_wait = 3;
    @(negedge clk); chk("lat memAddr", memAddr, 32'h10C); chk("lat pcOut", pcOut, 32'h108);
    nx(); redirect = 1; redirectTarget = 32'h200;
    @(negedge clk); chk("rd memReq", memReq, 1); chk("rd memAddr", memAddr, 32'h10C);
    nx(); redirect = 0;
    @(negedge clk); chk("rd hold memAddr", memAddr, 32'h10C); chk("rd flushed", instrValid, 0);
    nx();
    @(negedge clk); chk("rd ready memAddr", memAddr, 32'h10C);
    nx(); mem_wait = 0;
    @(negedge clk); chk("rd new memAddr", memAddr, 32'h200); chk("rd dropped", instrValid, 0);
    nx(); mem_wait = 2;
    @(negedge clk); chk("rd pcOut", pcOut, 32'h200); chk("rd instr", instruction, 32'h9C37_79B9); chk("rd valid", instrValid, 1);
    nx(); halt = 1;
    @(negedge clk); chk("halt pending", memReq, 1); chk("halt memAddr", memAddr, 32'h204);
    nx();
    @(negedge clk); chk("halt complete", memReq, 1);
    nx();
    @(negedge clk); chk("halt running", running, 0); chk("halt memReq", memReq, 0); chk("halt buf", instrValid, 1); chk("halt pcOut", pcOut, 32'h204);
    nx(); halt = 0;
    @(negedge clk); chk("idle no resume", memReq, 0); chk("idle consumed", instrValid, 0);
    nx(); mem_wait = 1000; start = 1; startAddress = 32'h300;
    nx(); start = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (memFault) break;
      n += int'(memReq);
      nx();
    end
    chk("timeout reqs", n, WL);
    chk("timeout fault", memFault, 1);
    chk("timeout memReq", memReq, 0);
    nx(); mem_wait = 0; start = 1; startAddress = 32'h0;
    @(negedge clk); chk("fault held", memFault, 1);
    nx(); start = 0;
    @(negedge clk); chk("restart fault", memFault, 0); chk("restart memAddr", memAddr, 0); chk("restart memReq", memReq, 1);
    nx(); redirect = 1; redirectTarget = 32'h202;
    nx(); redirect = 0;
    @(negedge clk); chk("misalign fault", memFault, 1); chk("misalign valid", instrValid, 0); chk("misalign memReq", memReq, 0);
    nx(); mem_wait = 6; start = 1; startAddress = 32'h400;
    nx(); start = 0;
    @(negedge clk); chk("mid memReq", memReq, 1); chk("mid memAddr", memAddr, 32'h400);
    nx(); reset = 1;
    nx(); reset = 0;
    @(negedge clk); chk("mid rst memReq", memReq, 0); chk("mid rst pcOut", pcOut, 0); chk("mid rst memAddr", memAddr, 0);
    rnd = 1;
    repeat (4000) begin
      nx();
      reset = ($urandom_range(0, 599) == 0);
      stall = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 29) == 0) halt = !halt;
      start = ($urandom_range(0, 9) == 0);
      startAddress = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
      if ($urandom_range(0, 9) == 0) startAddress[1:0] = 2'($urandom_range(1, 3));
      redirect = ($urandom_range(0, 11) == 0);
      redirectTarget = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) redirectTarget[0] = 1'b1;
    end
    nx();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
